// File: rtl/cmyk_pkg.sv
// Shared types and constants for the CMYK frame scheduler.
// State encoding and FIFO word marker layout.
package cmyk_pkg;

  localparam int DEF_PRECISION = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int MARK_W   = 3;
  localparam int MARK_SOF = 0;
  localparam int MARK_EOL = 1;
  localparam int MARK_EOF = 2;

endpackage

// File: rtl/rgb_to_cmyk.sv
// RGB to CMYK converter with a fixed-depth free-running pipe.
// K = max' ; C/M/Y = max - channel (under-colour removal form).
module rgb_to_cmyk #(
  parameter int P   = 8,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] r,
  input  logic [P-1:0] g,
  input  logic [P-1:0] b,
  output logic [P-1:0] c,
  output logic [P-1:0] m,
  output logic [P-1:0] y,
  output logic [P-1:0] k
);

  logic [P-1:0]   mx;
  logic [4*P-1:0] pipe [LAT];

  // largest channel sets the black level
  always_comb begin
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
  end

  // data pipe; validity is tracked by the caller
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {mx - r, mx - g, mx - b, ~mx};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {c, m, y, k} = pipe[LAT-1];

endmodule

// File: rtl/cmyk_frame_scheduler.sv
// Frame sequencer around rgb_to_cmyk with credit-based input
// and a first-word fall-through output FIFO.
module cmyk_frame_scheduler
  import cmyk_pkg::*;
#(
  parameter int COLOR_PRECISION = DEF_PRECISION,
  parameter int CONV_LATENCY    = 2,
  parameter int OUT_DEPTH       = 4,
  parameter int H_RES           = 4,
  parameter int V_RES           = 2
) (
  input  logic                       i_sysclk,
  input  logic                       i_arst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_rgb_valid,
  output logic                       o_rgb_ready,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  output logic                       o_cmyk_valid,
  input  logic                       i_cmyk_ready,
  output logic [COLOR_PRECISION-1:0] o_C,
  output logic [COLOR_PRECISION-1:0] o_M,
  output logic [COLOR_PRECISION-1:0] o_Y,
  output logic [COLOR_PRECISION-1:0] o_K,
  output logic                       o_sof,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int P  = COLOR_PRECISION;
  localparam int DW = 4 * P;
  localparam int WW = DW + MARK_W;
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(2 * OUT_DEPTH + 2);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_t            state, state_nx;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              accept, exit, pop, flush;
  logic              line_end, frame_end;
  logic [MARK_W-1:0] mk_in;
  logic [CONV_LATENCY-1:0] vld;
  logic [MARK_W-1:0] mk [CONV_LATENCY];
  logic [P-1:0]      cv_c, cv_m, cv_y, cv_k;
  logic [WW-1:0]     mem [OUT_DEPTH];
  logic [WW-1:0]     head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, inflight;

  assign line_end  = (x == XW'(H_RES - 1));
  assign frame_end = line_end && (y == YW'(V_RES - 1));
  assign flush     = i_abort && (state == S_RUN || state == S_DRAIN);
  assign exit      = vld[CONV_LATENCY-1];

  assign o_rgb_ready  = (state == S_RUN) &&
                        ((count + inflight) < CW'(OUT_DEPTH));
  assign accept       = i_rgb_valid && o_rgb_ready;
  assign o_cmyk_valid = (count != '0);
  assign pop          = o_cmyk_valid && i_cmyk_ready;

  assign head  = o_cmyk_valid ? mem[rd_ptr] : '0;
  assign o_sof = head[DW + MARK_SOF];
  assign o_eol = head[DW + MARK_EOL];
  assign o_eof = head[DW + MARK_EOF];
  assign {o_C, o_M, o_Y, o_K} = head[DW-1:0];

  rgb_to_cmyk #(
    .P   (P),
    .LAT (CONV_LATENCY)
  ) u_conv (
    .clk (i_sysclk),
    .rst (i_arst),
    .r   (i_R),
    .g   (i_G),
    .b   (i_B),
    .c   (cv_c),
    .m   (cv_m),
    .y   (cv_y),
    .k   (cv_k)
  );

  // markers for the pixel being accepted now
  always_comb begin
    mk_in           = '0;
    mk_in[MARK_SOF] = (x == '0) && (y == '0);
    mk_in[MARK_EOL] = line_end;
    mk_in[MARK_EOF] = frame_end;
  end

  // next state and status outputs
  always_comb begin
    state_nx = state;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start && !i_abort) state_nx = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (i_abort) state_nx = S_IDLE;
        else if (accept && frame_end) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (i_abort) state_nx = S_IDLE;
        else if (inflight == '0 &&
                 (count == '0 || (count == CW'(1) && pop)))
          state_nx = S_DONE;
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_sysclk) begin
    if (i_arst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // raster position of the next pixel to accept
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      x <= '0;
      y <= '0;
    end else if (state == S_IDLE && i_start && !i_abort) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (line_end) begin
        x <= '0;
        y <= (y == YW'(V_RES - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // valid/marker shadow running beside the converter
  always_ff @(posedge i_sysclk) begin
    if (i_arst || flush) begin
      vld <= '0;
      for (int i = 0; i < CONV_LATENCY; i++) mk[i] <= '0;
    end else begin
      vld[0] <= accept;
      mk[0]  <= mk_in;
      for (int i = 1; i < CONV_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        mk[i]  <= mk[i-1];
      end
    end
  end

  // pixels launched but not yet in the FIFO
  always_ff @(posedge i_sysclk) begin
    if (i_arst || flush) inflight <= '0;
    else inflight <= inflight + CW'(accept) - CW'(exit);
  end

  // FIFO storage
  always_ff @(posedge i_sysclk) begin
    if (exit) mem[wr_ptr] <= {mk[CONV_LATENCY-1], cv_c, cv_m, cv_y, cv_k};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_sysclk) begin
    if (i_arst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (exit)
        wr_ptr <= (wr_ptr == AW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(exit) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_cmyk_frame_scheduler.sv
// Directed bench for cmyk_frame_scheduler.
// Hand-computed CMYK table and marker pattern for an 8-pixel frame.
module tb_cmyk_frame_scheduler;

  logic       clk;
  logic       i_arst, i_start, i_abort;
  logic       i_rgb_valid, o_rgb_ready;
  logic [7:0] i_R, i_G, i_B;
  logic       o_cmyk_valid, i_cmyk_ready;
  logic [7:0] o_C, o_M, o_Y, o_K;
  logic       o_sof, o_eol, o_eof, o_busy, o_done;

  cmyk_frame_scheduler dut (
    .i_sysclk     (clk),
    .i_arst       (i_arst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_rgb_valid  (i_rgb_valid),
    .o_rgb_ready  (o_rgb_ready),
    .i_R          (i_R),
    .i_G          (i_G),
    .i_B          (i_B),
    .o_cmyk_valid (o_cmyk_valid),
    .i_cmyk_ready (i_cmyk_ready),
    .o_C          (o_C),
    .o_M          (o_M),
    .o_Y          (o_Y),
    .o_K          (o_K),
    .o_sof        (o_sof),
    .o_eol        (o_eol),
    .o_eof        (o_eof),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  pr [8] = '{8'd255, 8'd255, 8'd0, 8'd0,
                          8'd10, 8'd200, 8'd0, 8'd1};
  logic [7:0]  pg [8] = '{8'd255, 8'd0, 8'd255, 8'd0,
                          8'd20, 8'd100, 8'd128, 8'd2};
  logic [7:0]  pb [8] = '{8'd255, 8'd0, 8'd0, 8'd0,
                          8'd30, 8'd50, 8'd64, 8'd3};
  logic [31:0] exp_w [8] = '{32'h00000000, 32'h00FFFF00,
                             32'hFF00FF00, 32'h000000FF,
                             32'h140A00E1, 32'h00649637,
                             32'h8000407F, 32'h020100FC};
  logic [2:0]  exp_m [8] = '{3'b100, 3'b000, 3'b000, 3'b010,
                             3'b000, 3'b000, 3'b000, 3'b011};

  int          cyc = 0;
  logic [34:0] out_q [$];
  int          pop_cyc [$];
  int          acc_cyc [$];
  int          done_n = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (i_rgb_valid && o_rgb_ready) acc_cyc.push_back(cyc);
    if (o_cmyk_valid && i_cmyk_ready) begin
      out_q.push_back({o_sof, o_eol, o_eof, o_C, o_M, o_Y, o_K});
      pop_cyc.push_back(cyc);
    end
    if (o_done) begin
      done_n       <= done_n + 1;
      done_cyc     <= cyc;
      busy_at_done <= o_busy;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    step(1);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic send_px(input int i);
    int t = 0;
    i_rgb_valid = 1'b1;
    i_R = pr[i];
    i_G = pg[i];
    i_B = pb[i];
    @(negedge clk);
    while (!o_rgb_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_rgb_ready) check($sformatf("send_to_px%0d", i), 0, 1);
    @(posedge clk);
    #1;
    i_rgb_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_n == d0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done_n != d0), 1);
  endtask

  task automatic verify(input string tag, input int base);
    check({tag, "_count"}, 64'(out_q.size() - base), 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < out_q.size())
        check($sformatf("%s_px%0d", tag, i),
              64'(out_q[base+i]), 64'({exp_m[i], exp_w[i]}));
      else
        check($sformatf("%s_px%0d_missing", tag, i), 0, 1);
    end
  endtask

  int a0, p0, d0, pa;

  initial begin
    i_arst = 1'b1;
    i_start = 1'b1;
    i_abort = 1'b0;
    i_rgb_valid = 1'b0;
    i_R = '0;
    i_G = '0;
    i_B = '0;
    i_cmyk_ready = 1'b1;

    step(3);
    @(negedge clk);
    check("rst_rgb_ready", 64'(o_rgb_ready), 0);
    check("rst_cmyk_valid", 64'(o_cmyk_valid), 0);
    check("rst_markers", 64'({o_sof, o_eol, o_eof}), 0);
    check("rst_busy", 64'(o_busy), 0);
    check("rst_done", 64'(o_done), 0);
    check("rst_data", 64'({o_C, o_M, o_Y, o_K}), 0);
    @(posedge clk);
    #1;
    i_arst = 1'b0;
    i_start = 1'b0;
    step(2);
    @(negedge clk);
    check("idle_busy", 64'(o_busy), 0);
    check("idle_ready", 64'(o_rgb_ready), 0);

    a0 = acc_cyc.size();
    p0 = out_q.size();
    d0 = done_n;
    start_frame();
    for (int i = 0; i < 8; i++) send_px(i);
    wait_done(d0);
    step(4);
    verify("map", p0);
    if (out_q.size() >= p0 + 8 && acc_cyc.size() > a0) begin
      check("latency", 64'(pop_cyc[p0] - acc_cyc[a0]), 3);
      check("done_gap", 64'(done_cyc - pop_cyc[p0+7]), 1);
    end
    check("done_once", 64'(done_n - d0), 1);
    check("busy_at_done", 64'(busy_at_done), 0);

    a0 = acc_cyc.size();
    p0 = out_q.size();
    d0 = done_n;
    i_cmyk_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 4; i++) send_px(i);
    i_rgb_valid = 1'b1;
    i_R = pr[4];
    i_G = pg[4];
    i_B = pb[4];
    step(20);
    @(negedge clk);
    check("bp_accepts", 64'(acc_cyc.size() - a0), 4);
    check("bp_ready_low", 64'(o_rgb_ready), 0);
    check("bp_valid_held", 64'(o_cmyk_valid), 1);
    step(1);
    i_cmyk_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_px(i);
    wait_done(d0);
    step(4);
    verify("bp", p0);

    d0 = done_n;
    start_frame();
    for (int i = 0; i < 3; i++) send_px(i);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    pa = out_q.size();
    @(negedge clk);
    check("abort_busy", 64'(o_busy), 0);
    check("abort_valid", 64'(o_cmyk_valid), 0);
    check("abort_ready", 64'(o_rgb_ready), 0);
    step(10);
    check("abort_no_out", 64'(out_q.size() - pa), 0);
    check("abort_no_done", 64'(done_n - d0), 0);

    p0 = out_q.size();
    d0 = done_n;
    start_frame();
    for (int i = 0; i < 8; i++) send_px(i);
    wait_done(d0);
    step(4);
    verify("restart", p0);

    p0 = out_q.size();
    d0 = done_n;
    start_frame();
    for (int i = 0; i < 2; i++) send_px(i);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    for (int i = 2; i < 8; i++) send_px(i);
    wait_done(d0);
    step(4);
    verify("start_in_run", p0);

    step(2);
    i_start = 1'b1;
    i_abort = 1'b1;
    step(1);
    i_start = 1'b0;
    i_abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 64'(o_busy), 0);
    check("sa_ready", 64'(o_rgb_ready), 0);
    step(3);
    @(negedge clk);
    check("sa_still_idle", 64'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
